ps2_kb_regs: RTL and testbench

PS/2 keyboard receiver with a scan-code FIFO, exposed as read-only 32-bit registers on the memory controller's keyboard window (0x2xxxxxxx). The block samples the external PS/2 clock and data lines, deframes 11-bit frames, and buffers received codes. It answers `kb_read`/`kb_addr` with `kb_rdata` combinationally, so the controller's single-cycle load completes in the same cycle. A read of the DATA register pops the FIFO.

---
 rtl/ps2_kb_regs.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_kb_regs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_regs.sv
// PS/2 keyboard receiver with scan-code FIFO behind a read-only register window.
// Define KB_BREAK_DECODE_EN to fold 0xE0/0xF0 prefixes into DATA[10:9] flags.
module ps2_kb_regs #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        kb_read,
    input  logic [7:0]  kb_addr,
    output logic [31:0] kb_rdata
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef KB_BREAK_DECODE_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_p0, clk_p1, dat_p0, dat_p1;
    logic          clk_filt, fall;
    logic [FW-1:0] filt_cnt;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          timeout, stop_fall, frame_ok, byte_ok, frame_err;
    logic          push_req, push, pop, full, rd_status, rd_data;
    logic [EW-1:0] push_ent, head, last_ent;
    logic          last_vld, ovf, err;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [5:0]    sel;
    logic          addr_lsb_unused;

    assign addr_lsb_unused = ^kb_addr[1:0];

    function automatic logic [31:0] fmt_entry(input logic [EW-1:0] e);
        logic [31:0] r;
        r      = '0;
        r[7:0] = e[7:0];
        r[8]   = 1'b1;
`ifdef KB_BREAK_DECODE_EN
        r[9]   = e[8];
        r[10]  = e[9];
`endif
        return r;
    endfunction

    // Synchronizers; lines idle high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk;
            clk_p1 <= clk_p0;
            dat_p0 <= ps2_data;
            dat_p1 <= dat_p0;
        end
    end

    // Glitch filter: state flips after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_p1 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_p1;
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign timeout   = (state != S_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign stop_fall = (state == S_STOP) && fall;
    assign frame_ok  = dat_p1 && (^{shreg, par_bit});
    assign byte_ok   = stop_fall && frame_ok;
    assign frame_err = (stop_fall && !frame_ok) || timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            tcnt    <= '0;
        end else begin
            if (fall || state == S_IDLE)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
            if (timeout) begin
                state <= S_IDLE;
            end else if (fall) begin
                case (state)
                    S_IDLE: if (!dat_p1) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                    S_DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: state <= S_STOP;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

    // Shift register and parity capture carry no reset
    always_ff @(posedge clk) begin
        if (fall && state == S_DATA)   shreg   <= {dat_p1, shreg[7:1]};
        if (fall && state == S_PARITY) par_bit <= dat_p1;
    end

`ifdef KB_BREAK_DECODE_EN
    logic ext_pend, brk_pend, is_prefix;
    assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
    assign push_req  = byte_ok && !is_prefix;
    assign push_ent  = {ext_pend, brk_pend, shreg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_err || push_req) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_ok) begin
            if (shreg == 8'hE0) ext_pend <= 1'b1;
            if (shreg == 8'hF0) brk_pend <= 1'b1;
        end
    end
`else
    assign push_req = byte_ok;
    assign push_ent = shreg;
`endif

    assign sel       = kb_addr[7:2];
    assign rd_status = kb_read && (sel == 6'd0);
    assign rd_data   = kb_read && (sel == 6'd1);
    assign pop       = rd_data && (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs
    assign push      = push_req && (!full || pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            last_ent <= '0;
            last_vld <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            ovf <= (ovf && !rd_status) || (push_req && full && !pop);
            err <= (err && !rd_status) || frame_err;
            if (push_req) begin
                last_ent <= push_ent;
                last_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        kb_rdata = '0;
        case (sel)
            6'd0: begin
                kb_rdata[0]       = (count != '0);
                kb_rdata[1]       = ovf;
                kb_rdata[2]       = err;
                kb_rdata[8 +: CW] = count;
            end
            6'd1:    if (count != '0) kb_rdata = fmt_entry(head);
            6'd2:    if (last_vld)    kb_rdata = fmt_entry(last_ent);
            default: kb_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_ps2_kb_regs.sv
// Directed bench for ps2_kb_regs: queue-based register model checked every cycle.
module tb_ps2_kb_regs;
    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TOUT  = 300;
    localparam int H     = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        kb_read = 1'b0;
    logic [7:0]  kb_addr = 8'h00;
    logic [31:0] kb_rdata;

    ps2_kb_regs #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kb_read(kb_read), .kb_addr(kb_addr), .kb_rdata(kb_rdata)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          busy = 1'b1;
    bit          lit_on = 1'b0;
    logic [31:0] lit_exp = '0;
    logic [10:0] q[$];
    bit          m_ovf = 0, m_err = 0, pend_e = 0, pend_b = 0;
    logic [31:0] m_last = '0;
    int          rot = 0;
    logic [7:0]  addr_tab [6] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h40, 8'hFC};

    function automatic logic [31:0] exp_rd(input logic [7:0] a);
        logic [31:0] r;
        r = '0;
        case (a[7:2])
            6'd0: r = {19'd0, 5'(q.size()), 5'd0, m_err, m_ovf, q.size() != 0};
            6'd1: if (q.size() != 0) r = {21'd0, q[0]};
            6'd2: r = m_last;
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) begin
                n_vec++;
                if (kb_rdata !== exp_rd(kb_addr)) begin
                    n_bad++;
                    $display("FAIL model addr=%h got=%h want=%h", kb_addr, kb_rdata, exp_rd(kb_addr));
                end
            end
            if (lit_on) begin
                n_vec++;
                if (kb_rdata !== lit_exp) begin
                    n_bad++;
                    $display("FAIL read addr=%h got=%h want=%h", kb_addr, kb_rdata, lit_exp);
                end
            end
        end
    end

    task automatic m_push(input logic [10:0] e);
        m_last = {21'd0, e};
        if (q.size() < DEPTH) q.push_back(e);
        else m_ovf = 1'b1;
    endtask

    task automatic m_accept(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_err = 1'b1; pend_e = 1'b0; pend_b = 1'b0;
        end else begin
`ifdef KB_BREAK_DECODE_EN
            if (b == 8'hE0) pend_e = 1'b1;
            else if (b == 8'hF0) pend_b = 1'b1;
            else begin
                m_push({pend_e, pend_b, 1'b1, b});
                pend_e = 1'b0; pend_b = 1'b0;
            end
`else
            m_push({2'b00, 1'b1, b});
`endif
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (!kb_read) begin
                kb_addr = addr_tab[rot];
                rot = (rot + 1) % 6;
            end
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] want);
        kb_addr = a; kb_read = 1'b1; lit_exp = want; lit_on = 1'b1;
        @(posedge clk);
        if (a[7:2] == 6'd1 && q.size() != 0) void'(q.pop_front());
        if (a[7:2] == 6'd0) begin m_ovf = 1'b0; m_err = 1'b0; end
        #1 kb_read = 1'b0; lit_on = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ok, input bit rd_stop, input logic [31:0] want);
        logic [10:0] fr;
        logic        par;
        par = (~^b) ^ !ok;
        fr  = {1'b1, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = fr[i];
            cyc(H);
            if (i == 10) busy = 1'b1;
            ps2_clk = 1'b0;
            if (i == 10) begin
                if (rd_stop) begin
                    cyc(2 + FILT);
                    kb_addr = 8'h04; kb_read = 1'b1; lit_exp = want; lit_on = 1'b1;
                    @(posedge clk);
                    if (q.size() != 0) void'(q.pop_front());
                    m_accept(b, ok);
                    #1 kb_read = 1'b0; lit_on = 1'b0;
                end else begin
                    repeat (FILT + 3) @(posedge clk);
                    m_accept(b, ok);
                    #1;
                end
                busy = 1'b0;
            end
            cyc(H);
            ps2_clk = 1'b1;
            cyc(H);
        end
    endtask

    task automatic partial(input int nbits);
        logic [7:0] pat;
        pat = 8'b1010_1010;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = pat[i];
            cyc(H);
            ps2_clk = 1'b0;
            cyc(H);
            ps2_clk = 1'b1;
            cyc(H);
        end
        ps2_data = 1'b1;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        busy = 1'b0;
        cyc(FILT + 4);

        // Reset state
        rd(8'h00, 32'h0); rd(8'h04, 32'h0); rd(8'h08, 32'h0); rd(8'h0C, 32'h0);

        // Single frame
        send_frame(8'h1C, 1'b1, 1'b0, 32'h0);
        rd(8'h00, 32'h0000_0101); rd(8'h04, 32'h0000_011C); rd(8'h00, 32'h0);

        // Bad parity
        send_frame(8'h1C, 1'b0, 1'b0, 32'h0);
        rd(8'h00, 32'h0000_0004); rd(8'h00, 32'h0); rd(8'h04, 32'h0);

        // Overflow
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 32'h0);
        rd(8'h00, 32'h0000_0803);
        for (int i = 1; i <= 8; i++) rd(8'h04, 32'h100 | i);
        rd(8'h04, 32'h0); rd(8'h00, 32'h0);

        // Timeout then resynchronization
        partial(4);
        busy = 1'b1;
        cyc(TOUT + 10);
        m_err = 1'b1; pend_e = 1'b0; pend_b = 1'b0;
        busy = 1'b0;
        send_frame(8'h1C, 1'b1, 1'b0, 32'h0);
        rd(8'h00, 32'h0000_0105); rd(8'h04, 32'h0000_011C);

        // Prefix handling
        send_frame(8'hE0, 1'b1, 1'b0, 32'h0);
        send_frame(8'hF0, 1'b1, 1'b0, 32'h0);
        send_frame(8'h75, 1'b1, 1'b0, 32'h0);
`ifdef KB_BREAK_DECODE_EN
        rd(8'h00, 32'h0000_0101); rd(8'h04, 32'h0000_0775); rd(8'h08, 32'h0000_0775);
`else
        rd(8'h00, 32'h0000_0301);
        rd(8'h04, 32'h1E0); rd(8'h04, 32'h1F0); rd(8'h04, 32'h175); rd(8'h08, 32'h175);
`endif

        // Push and pop in the same cycle on a full FIFO
        for (int i = 0; i < 8; i++) send_frame(8'h21 + 8'(i), 1'b1, 1'b0, 32'h0);
        send_frame(8'h29, 1'b1, 1'b1, 32'h0000_0121);
        rd(8'h00, 32'h0000_0801);
        for (int i = 2; i <= 9; i++) rd(8'h04, 32'h120 + i);
        rd(8'h00, 32'h0);

        // Reset in the middle of a frame with data buffered
        send_frame(8'h33, 1'b1, 1'b0, 32'h0);
        send_frame(8'h44, 1'b1, 1'b0, 32'h0);
        partial(3);
        rst = 1'b1;
        q.delete(); m_ovf = 0; m_err = 0; pend_e = 0; pend_b = 0; m_last = '0;
        cyc(2);
        rst = 1'b0;
        cyc(FILT + 4);
        rd(8'h00, 32'h0); rd(8'h08, 32'h0);
        send_frame(8'h1C, 1'b1, 1'b0, 32'h0);
        rd(8'h04, 32'h0000_011C);

        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
